// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel word as start, LSB-first data, optional parity
// and stop bits, one bit per clock, with back-to-back frames accepted from the stop state.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                  r_state;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_par;
    logic                    r_par_en;
    logic                    r_tx;
    logic                    r_busy;
    logic                    w_accept;

    assign w_accept = Data_valid && ((r_state == StIdle) || (r_state == StStop));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            r_data    <= '0;
            r_par     <= 1'b0;
            r_par_en  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            // Line and busy are registered from the state held this cycle, so they trail the
            // state by one edge and the start bit appears the edge after accept.
            case (r_state)
                StIdle:   r_tx <= 1'b1;
                StStart:  r_tx <= 1'b0;
                StData:   r_tx <= r_data[r_bit_cnt];
                StParity: r_tx <= r_par;
                StStop:   r_tx <= 1'b1;
                default:  r_tx <= 1'b1;
            endcase
            r_busy <= (r_state != StIdle);

            if (w_accept) begin
                r_data   <= P_DATA;
                r_par    <= par_bit;
                r_par_en <= PAR_EN;
            end

            case (r_state)
                StIdle: begin
                    if (w_accept) r_state <= StStart;
                end
                StStart: begin
                    r_state   <= StData;
                    r_bit_cnt <= '0;
                end
                StData: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        r_state <= r_par_en ? StParity : StStop;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                StParity: r_state <= StStop;
                StStop:   r_state <= w_accept ? StStart : StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    assign TX_OUT = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl: each task drives one scenario and compares
// TX_OUT/busy against hand-computed bit sequences, sampled 1 time unit after each rising edge.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_valid;
    logic       PAR_EN;
    logic       par_bit;
    logic       TX_OUT;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .PAR_EN     (PAR_EN),
        .par_bit    (par_bit),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_power_up();
        RST = 1'b1; Data_valid = 1'b1; P_DATA = 8'hAA; PAR_EN = 1'b0; par_bit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({TX_OUT, busy} !== 2'b10) begin
                n_err++;
                $display("FAIL power_up[%0d]: tx/busy=%b%b expected 10", i, TX_OUT, busy);
            end
        end
        RST = 1'b0;
        tick();
        n_cmp++;
        if ({TX_OUT, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL power_up_accept_edge: tx/busy=%b%b expected 10", TX_OUT, busy);
        end
        Data_valid = 1'b0;
        tick();
        n_cmp++;
        if ({TX_OUT, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL power_up_start_bit: tx/busy=%b%b expected 01", TX_OUT, busy);
        end
        for (int i = 0; i < 12; i++) tick();
        n_cmp++;
        if ({TX_OUT, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL power_up_drain: tx/busy=%b%b expected 10", TX_OUT, busy);
        end
    endtask

    task automatic test_parity();
        logic [10:0] exp_bits = 11'b1_0_10100101_0;  // stop, par, data MSB..LSB, start
        P_DATA = 8'hA5; PAR_EN = 1'b1; par_bit = 1'b0; Data_valid = 1'b1;
        tick();
        Data_valid = 1'b0; P_DATA = 8'h00;
        for (int i = 0; i < 11; i++) begin
            tick();
            n_cmp++;
            if (TX_OUT !== exp_bits[i] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL parity_bit[%0d]: tx/busy=%b%b expected %b1",
                         i, TX_OUT, busy, exp_bits[i]);
            end
        end
        tick();
        n_cmp++;
        if ({TX_OUT, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL parity_end: tx/busy=%b%b expected 10", TX_OUT, busy);
        end
    endtask

    task automatic test_no_parity();
        logic [9:0] exp_bits = 10'b1_00111100_0;
        P_DATA = 8'h3C; PAR_EN = 1'b0; par_bit = 1'b1; Data_valid = 1'b1;
        tick();
        Data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (TX_OUT !== exp_bits[i] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL no_parity_bit[%0d]: tx/busy=%b%b expected %b1",
                         i, TX_OUT, busy, exp_bits[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({TX_OUT, busy} !== 2'b10) begin
                n_err++;
                $display("FAIL no_parity_idle[%0d]: tx/busy=%b%b expected 10", i, TX_OUT, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        // frame 1 (0x01) in bits 10:0, frame 2 (0xFF) in bits 21:11
        logic [21:0] exp_bits = {11'b1_1_11111111_0, 11'b1_1_00000001_0};
        P_DATA = 8'h01; PAR_EN = 1'b1; par_bit = 1'b1; Data_valid = 1'b1;
        tick();
        P_DATA = 8'hFF;
        for (int i = 0; i < 22; i++) begin
            if (i == 13) Data_valid = 1'b0;
            tick();
            n_cmp++;
            if (TX_OUT !== exp_bits[i] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_bit[%0d]: tx/busy=%b%b expected %b1",
                         i, TX_OUT, busy, exp_bits[i]);
            end
        end
        tick();
        n_cmp++;
        if ({TX_OUT, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_end: tx/busy=%b%b expected 10", TX_OUT, busy);
        end
    endtask

    task automatic test_ignored_request();
        logic [9:0] exp_bits = 10'b1_00001111_0;
        P_DATA = 8'h0F; PAR_EN = 1'b0; par_bit = 1'b0; Data_valid = 1'b1;
        tick();
        Data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            Data_valid = (i == 3);
            if (i == 3) P_DATA = 8'h55;
            if (i == 4) begin P_DATA = 8'hF0; PAR_EN = 1'b1; par_bit = 1'b1; end
            if (i == 6) P_DATA = 8'hAA;
            tick();
            n_cmp++;
            if (TX_OUT !== exp_bits[i] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL ignored_bit[%0d]: tx/busy=%b%b expected %b1",
                         i, TX_OUT, busy, exp_bits[i]);
            end
        end
        Data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({TX_OUT, busy} !== 2'b10) begin
                n_err++;
                $display("FAIL ignored_no_second[%0d]: tx/busy=%b%b expected 10",
                         i, TX_OUT, busy);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] exp_bits = 11'b1_1_10000000_0;
        P_DATA = 8'h00; PAR_EN = 1'b0; par_bit = 1'b0; Data_valid = 1'b1;
        tick();
        Data_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if ({TX_OUT, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_pre_4th_bit: tx/busy=%b%b expected 01", TX_OUT, busy);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_cmp++;
        if ({TX_OUT, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_mid_frame: tx/busy=%b%b expected 10", TX_OUT, busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({TX_OUT, busy} !== 2'b10) begin
                n_err++;
                $display("FAIL reset_no_resume[%0d]: tx/busy=%b%b expected 10", i, TX_OUT, busy);
            end
        end
        P_DATA = 8'h80; PAR_EN = 1'b1; par_bit = 1'b1; Data_valid = 1'b1;
        tick();
        Data_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            n_cmp++;
            if (TX_OUT !== exp_bits[i] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL reset_after_bit[%0d]: tx/busy=%b%b expected %b1",
                         i, TX_OUT, busy, exp_bits[i]);
            end
        end
        tick();
        n_cmp++;
        if ({TX_OUT, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_after_end: tx/busy=%b%b expected 10", TX_OUT, busy);
        end
    endtask

    initial begin
        test_power_up();
        test_parity();
        test_no_parity();
        test_back_to_back();
        test_ignored_request();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame.
REQ-002 Port: CLK  input  1  clock; one bit period equals one CLK cycle.
REQ-003 Port: RST  input  1  reset; synchronous, active-high.
REQ-004 Port: P_DATA  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 Port: Data_valid  input  1  request strobe; P_DATA, par_bit and PAR_EN are valid in the same cycle.
REQ-006 Port: PAR_EN  input  1  1 = insert a parity bit between the last data bit and the stop bit.
REQ-007 Port: par_bit  input  1  parity bit, combinational from the parity calculator fed by the same P_DATA.
REQ-008 Port: TX_OUT  output  1  serial line, registered, idle high.
REQ-009 Port: busy  output  1  registered; high while a frame is in progress.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, encoded in a registered state variable.
REQ-011 Accept SHALL occur on a rising edge where Data_valid=1 and state is IDLE or STOP, and only then.
REQ-012 On accept, the block SHALL latch P_DATA, par_bit and PAR_EN into internal registers.
- The frame then uses only the latched values.
- Later changes on P_DATA, par_bit and PAR_EN have no effect on the frame in progress.
REQ-013 Data_valid SHALL be ignored in START, DATA and PARITY, with no queuing or side effect.
REQ-014 Transitions SHALL be:
- IDLE -> START on accept.
- START -> DATA after 1 cycle.
- DATA -> PARITY after DATA_WIDTH cycles when the latched PAR_EN=1; DATA -> STOP in that case when PAR_EN=0.
- PARITY -> STOP after 1 cycle.
- STOP -> START on accept; STOP -> IDLE otherwise.
REQ-015 TX_OUT SHALL be 1 in IDLE, 0 in START, the data bits in DATA, the latched par_bit in PARITY, and 1 in STOP.
- Data bits are sent LSB first, one bit per cycle.
REQ-016 A bit counter of width ceil(log2(DATA_WIDTH)) SHALL index the data bits.
- It clears on entry to DATA and increments each DATA cycle.
- The last data bit is index DATA_WIDTH-1; the counter never wraps into a ninth bit.
REQ-017 Latency: when accept happens at edge k, TX_OUT SHALL show the start bit from edge k+1 onward.
REQ-018 Frame length SHALL be DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 cycles without (11 or 10 at the default width).
REQ-019 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
- busy rises at the same edge at which TX_OUT first shows the start bit.
REQ-020 Back-to-back: on accept in STOP, the block SHALL move directly to START with no idle cycle between frames.
- busy stays 1 throughout.
REQ-021 A one-cycle Data_valid pulse SHALL be sufficient to start a frame.
- A Data_valid held high from IDLE starts a new frame each time the state reaches STOP.

Reset
REQ-022 At any rising edge with RST=1, the block SHALL set state to IDLE, TX_OUT to 1, busy to 0, and clear the bit counter and latched registers.
- This applies in every state, including mid-frame.
- RST has priority over Data_valid.
REQ-023 After RST deasserts, the block SHALL accept a new request on the first following edge that sees Data_valid=1.
- The aborted frame is not resumed.

Verification
REQ-024 The bench SHALL cover parity frame: P_DATA=0xA5, PAR_EN=1, par_bit=0, one-cycle Data_valid.
- Required TX_OUT: 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles.
- busy is high for exactly those 11 cycles.
REQ-025 The bench SHALL cover no parity: P_DATA=0x3C, PAR_EN=0.
- Required TX_OUT: 0,0,0,1,1,1,1,0,0,1 over 10 cycles, then idle 1.
REQ-026 The bench SHALL cover back-to-back: Data_valid held high with 0x01 then 0xFF, PAR_EN=1, par_bit=1.
- Required: stop bit of frame 1 is followed immediately by the start bit of frame 2.
- busy never drops between frames.
REQ-027 The bench SHALL cover ignored request and input stability.
- Stimulus: Data_valid pulse with 0x55 during the DATA state of a 0x0F frame; P_DATA toggled mid-frame.
- Required: the 0x0F frame is transmitted unchanged and no second frame follows.
REQ-028 The bench SHALL cover reset mid-frame: RST=1 for one cycle during the 4th data bit.
- Required: TX_OUT=1 and busy=0 at the next edge.
- A subsequent 0x80 request produces a complete, correct frame.
REQ-029 The bench SHALL cover power-up: RST held high for 3 cycles with Data_valid=1.
- Required: TX_OUT=1 and busy=0 throughout, and no frame starts until RST=0.
